multicycle_hart: RTL and testbench



---
 rtl/multicycle_hart.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_hart.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_hart.sv
// multicycle_hart: multi-cycle RV32I-subset hart (ADDI/XORI/ORI/ANDI, LUI,
// LB/LH/LW/LBU/LHU, SB/SH/SW) sequencing FETCH -> EXEC -> (MEM) over a single
// memory port with a ready handshake, so any memory latency is tolerated.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   mem_req/mem_we          request strobe and direction (1 = store)
//   mem_addr                byte address (pc in FETCH, effective address in MEM)
//   mem_wwidth/mem_wdata    store width and LSB-aligned store data
//   mem_rdata/mem_ready     read data and completion; handshake = req && ready
//   pc, halted, retired     architectural PC, sticky halt, retirement count
//   dbg_rsel/dbg_rdata      combinational debug read of the register file

package multicycle_hart_pkg;
  // Encoding matches funct3[1:0] of the store instructions.
  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;
endpackage

module multicycle_hart
  import multicycle_hart_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output write_width_t             mem_wwidth,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          pc,
  output logic                     halted,
  output logic [31:0]              retired,
  input  logic [$clog2(NREGS)-1:0] dbg_rsel,
  output logic [XLEN-1:0]          dbg_rdata
);

  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] xregs [NREGS];

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  logic [XLEN-1:0] i_imm, s_imm, u_imm;
  assign i_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign s_imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  // {imm[31:12], 12'b0} sign-extended; ir[31] fills the bits above 30.
  assign u_imm = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = xregs[rs1[RW-1:0]];
  assign rs2_val = xregs[rs2[RW-1:0]];

  // Decode. Register specifiers are only checked for fields the format uses.
  logic is_alu, is_lui, is_load, is_store, legal;
  logic rd_ok, rs1_ok, rs2_ok;
  assign rd_ok  = int'(rd)  < NREGS;
  assign rs1_ok = int'(rs1) < NREGS;
  assign rs2_ok = int'(rs2) < NREGS;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    is_alu   = 1'b0;
    is_lui   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OP_IMM:   is_alu   = funct3 inside {3'b000, 3'b100, 3'b110, 3'b111};
      OP_LUI:   is_lui   = 1'b1;
      OP_LOAD:  is_load  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE: is_store = funct3 inside {3'b000, 3'b001, 3'b010};
      default:  ;
    endcase
  end

  assign legal = (is_alu   && rd_ok && rs1_ok) ||
                 (is_lui   && rd_ok)           ||
                 (is_load  && rd_ok && rs1_ok) ||
                 (is_store && rs1_ok && rs2_ok);

  logic [XLEN-1:0] alu_val;
  always_comb begin
    alu_val = rs1_val + i_imm;
    case (funct3)
      3'b100:  alu_val = rs1_val ^ i_imm;
      3'b110:  alu_val = rs1_val | i_imm;
      3'b111:  alu_val = rs1_val & i_imm;
      default: ;
    endcase
  end

  logic [XLEN-1:0] load_val;
  always_comb begin
    load_val = {{(XLEN-31){mem_rdata[31]}}, mem_rdata[30:0]};
    case (funct3)
      3'b000:  load_val = {{(XLEN-8){mem_rdata[7]}},   mem_rdata[7:0]};
      3'b001:  load_val = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}},           mem_rdata[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}},          mem_rdata[15:0]};
      default: ;
    endcase
  end

  // Memory port. Derived from the registered state; reset masks the request
  // in the same cycle so an in-flight transaction is abandoned immediately.
  assign mem_req    = !reset && (state == FETCH || state == MEM);
  assign mem_we     = (state == MEM) && is_store;
  assign mem_addr   = (state == MEM) ? ea : pc;
  assign mem_wdata  = rs2_val;
  assign mem_wwidth = write_width_t'(funct3[1:0]);

  assign dbg_rdata  = (dbg_rsel == '0) ? '0 : xregs[dbg_rsel];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      ea      <= '0;
      retired <= '0;
      halted  <= 1'b0;
      // NOTE: the register file is architecturally reset, so it is a flop
      // array rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) xregs[i] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every read sees
      // the pre-edge value regardless of statement order.
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[31:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!legal) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (is_alu || is_lui) begin
            if (rd != 5'd0) xregs[rd[RW-1:0]] <= is_lui ? u_imm : alu_val;
            pc      <= pc + XLEN'(4);
            retired <= retired + 32'd1;
            state   <= FETCH;
          end else begin
            ea    <= rs1_val + (is_store ? s_imm : i_imm);
            state <= MEM;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (is_load && rd != 5'd0) xregs[rd[RW-1:0]] <= load_val;
            pc      <= pc + XLEN'(4);
            retired <= retired + 32'd1;
            state   <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_hart.sv
// Self-checking bench for multicycle_hart: a 256-byte little-endian memory
// model with a programmable number of wait cycles per request, plus a second
// NREGS=16 instance fed a constant instruction.
module tb_multicycle_hart;
  import multicycle_hart_pkg::*;

  logic         clock, reset;
  logic         mem_req, mem_we, mem_ready, halted;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, pc, retired, dbg_rdata;
  write_width_t mem_wwidth;
  logic [4:0]   dbg_rsel;

  logic         mem_req_e, mem_we_e, halted_e;
  logic [31:0]  mem_addr_e, mem_wdata_e, pc_e, retired_e, dbg_rdata_e;
  write_width_t mem_wwidth_e;
  logic [3:0]   dbg_rsel_e;
  logic [31:0]  mem_rdata_e;
  logic         mem_ready_e;

  int checks = 0;
  int failures = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  int store_count = 0;

  logic        tb_clr = 1'b0;
  logic        tb_we = 1'b0;
  logic [7:0]  tb_waddr = 8'h00;
  logic [31:0] tb_wdata = 32'h0;
  logic [7:0]  mem [256];
  logic [7:0]  ma;

  multicycle_hart #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) u_dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .halted(halted),
    .retired(retired), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  multicycle_hart #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) u_e (
    .clock(clock), .reset(reset), .mem_req(mem_req_e), .mem_we(mem_we_e),
    .mem_addr(mem_addr_e), .mem_wwidth(mem_wwidth_e), .mem_wdata(mem_wdata_e),
    .mem_rdata(mem_rdata_e), .mem_ready(mem_ready_e), .pc(pc_e), .halted(halted_e),
    .retired(retired_e), .dbg_rsel(dbg_rsel_e), .dbg_rdata(dbg_rdata_e)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  assign ma        = mem_addr[7:0];
  assign mem_ready = (wcnt >= wait_cfg);
  always_comb mem_rdata = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

  always @(posedge clock) begin
    if (reset)                     wcnt <= 0;
    else if (mem_req && mem_ready) wcnt <= 0;
    else if (mem_req)              wcnt <= wcnt + 1;
  end

  always @(posedge clock) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (tb_we) begin
      mem[tb_waddr]               <= tb_wdata[7:0];
      mem[8'(tb_waddr + 8'd1)]    <= tb_wdata[15:8];
      mem[8'(tb_waddr + 8'd2)]    <= tb_wdata[23:16];
      mem[8'(tb_waddr + 8'd3)]    <= tb_wdata[31:24];
    end else if (!reset && mem_req && mem_we && mem_ready) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_wwidth != write_byte) mem[8'(ma + 8'd1)] <= mem_wdata[15:8];
      if (mem_wwidth == write_word) begin
        mem[8'(ma + 8'd2)] <= mem_wdata[23:16];
        mem[8'(ma + 8'd3)] <= mem_wdata[31:24];
      end
      store_count <= store_count + 1;
    end
  end

  // The RV32E instance always fetches "addi x20,x0,1".
  assign mem_rdata_e = 32'h00100A13;
  assign mem_ready_e = 1'b1;
  assign dbg_rsel_e  = 4'd0;

  // ---------------- encoders and helpers ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_rsel = 5'(r);
    #1;
    v = dbg_rdata;
  endtask

  task automatic reset_on();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic reset_off();
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    @(negedge clock);
    tb_clr = 1'b1;
    @(negedge clock);
    tb_clr = 1'b0;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    @(negedge clock);
    tb_we    = 1'b1;
    tb_waddr = 8'(a);
    tb_wdata = w;
    @(negedge clock);
    tb_we    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset pc: got %h want 0", pc); end
    checks++; if (retired !== 32'h0) begin failures++; $display("FAIL reset retired: got %h want 0", retired); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset halted: got %b want 0", halted); end
    read_reg(1, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset x1: got %h want 0", v); end
    checks++; if (pc_e !== 32'h100) begin failures++; $display("FAIL reset rv32e pc: got %h want 100", pc_e); end
    reset_off();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL first fetch: req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); end
  endtask

  task automatic test_addi_seq();
    logic [31:0] v;
    reset_on(); clear_mem();
    put_word(0, enc_i(5, 0, 0, 15, 7'h13));
    put_word(4, enc_i(1, 15, 0, 15, 7'h13));
    put_word(8, enc_i(-1, 15, 0, 15, 7'h13));
    reset_off();
    step(2); read_reg(15, v);
    checks++; if (v !== 32'd5) begin failures++; $display("FAIL addi_seq x15 #1: got %h want 5", v); end
    step(2); read_reg(15, v);
    checks++; if (v !== 32'd6) begin failures++; $display("FAIL addi_seq x15 #2: got %h want 6", v); end
    step(2); read_reg(15, v);
    checks++; if (v !== 32'd5) begin failures++; $display("FAIL addi_seq x15 #3: got %h want 5", v); end
    checks++; if (pc !== 32'd12) begin failures++; $display("FAIL addi_seq pc: got %h want c", pc); end
    checks++; if (retired !== 32'd3) begin failures++; $display("FAIL addi_seq retired: got %0d want 3", retired); end
  endtask

  task automatic test_store_load();
    logic [31:0] v;
    reset_on(); clear_mem();
    put_word(0,  enc_i(96, 0, 0, 15, 7'h13));
    put_word(4,  enc_i(10, 0, 0, 14, 7'h13));
    put_word(8,  enc_s(0, 14, 15, 2));
    put_word(12, enc_i(0, 15, 2, 14, 7'h03));
    put_word(16, enc_i(1, 14, 0, 14, 7'h13));
    put_word(20, enc_s(0, 14, 15, 2));
    reset_off();
    step(15);
    checks++; if (mem_word(96) !== 32'd11) begin failures++; $display("FAIL store_load mem[96]: got %h want b", mem_word(96)); end
    read_reg(14, v);
    checks++; if (v !== 32'd11) begin failures++; $display("FAIL store_load x14: got %h want b", v); end
    checks++; if (retired !== 32'd6) begin failures++; $display("FAIL store_load retired: got %0d want 6", retired); end
  endtask

  task automatic test_wait_states();
    logic [31:0] v, exp_addr;
    reset_on(); clear_mem();
    put_word(0, enc_i(-1, 0, 0, 1, 7'h13));
    put_word(4, enc_s(100, 1, 0, 2));
    wait_cfg = 3;
    reset_off();
    for (int k = 0; k <= 14; k++) begin
      if (k <= 3 || (k >= 5 && k <= 8) || (k >= 10 && k <= 13)) begin
        exp_addr = (k <= 3) ? 32'd0 : (k <= 8) ? 32'd4 : 32'd100;
        checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
          failures++; $display("FAIL wait k=%0d: req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, exp_addr); end
        if (k >= 10) begin
          checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hFFFFFFFF || mem_wwidth !== write_word) begin
            failures++; $display("FAIL wait store k=%0d: we=%b wdata=%h width=%0d want 1 ffffffff 2", k, mem_we, mem_wdata, mem_wwidth); end
        end
      end
      if (k == 4) begin
        read_reg(1, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL wait x1 early: got %h want 0", v); end
      end
      if (k == 8) begin
        read_reg(1, v);
        checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL wait x1: got %h want ffffffff", v); end
      end
      if (k == 14) begin
        checks++; if (mem_word(100) !== 32'hFFFFFFFF) begin failures++; $display("FAIL wait mem[100]: got %h want ffffffff", mem_word(100)); end
        checks++; if (pc !== 32'd8 || retired !== 32'd2) begin
          failures++; $display("FAIL wait pc/retired: got %h/%0d want 8/2", pc, retired); end
      end
      if (k < 14) step(1);
    end
    wait_cfg = 0;
  endtask

  task automatic test_loads();
    logic [31:0] v;
    logic [31:0] exp_v [1:5];
    exp_v[1] = 32'hFFFFFFFF; exp_v[2] = 32'h000000FF; exp_v[3] = 32'hFFFF80FF;
    exp_v[4] = 32'h000080FF; exp_v[5] = 32'h000080FF;
    reset_on(); clear_mem();
    put_word(100, 32'h000080FF);
    put_word(0,  enc_i(100, 0, 0, 1, 7'h03));
    put_word(4,  enc_i(100, 0, 4, 2, 7'h03));
    put_word(8,  enc_i(100, 0, 1, 3, 7'h03));
    put_word(12, enc_i(100, 0, 5, 4, 7'h03));
    put_word(16, enc_i(50, 0, 0, 6, 7'h13));
    put_word(20, enc_i(50, 6, 2, 5, 7'h03));
    reset_off();
    step(17);
    for (int r = 1; r <= 5; r++) begin
      read_reg(r, v);
      checks++; if (v !== exp_v[r]) begin failures++; $display("FAIL loads x%0d: got %h want %h", r, v, exp_v[r]); end
    end
  endtask

  task automatic test_alu();
    logic [31:0] v;
    logic [31:0] exp_v [0:5];
    exp_v[0] = 32'h0;        exp_v[1] = 32'h7;  exp_v[2] = 32'hFFFFFFF8;
    exp_v[3] = 32'h37;       exp_v[4] = 32'h8;  exp_v[5] = 32'h80000000;
    reset_on(); clear_mem();
    put_word(0,  enc_i(5, 0, 0, 0, 7'h13));
    put_word(4,  enc_i(7, 0, 0, 1, 7'h13));
    put_word(8,  enc_i(-1, 1, 4, 2, 7'h13));
    put_word(12, enc_i(32'h30, 1, 6, 3, 7'h13));
    put_word(16, enc_i(32'h0F, 2, 7, 4, 7'h13));
    put_word(20, enc_u(32'h80000, 5));
    put_word(24, enc_s(200, 1, 0, 0));
    put_word(28, enc_s(204, 2, 0, 1));
    reset_off();
    step(18);
    for (int r = 0; r <= 5; r++) begin
      read_reg(r, v);
      checks++; if (v !== exp_v[r]) begin failures++; $display("FAIL alu x%0d: got %h want %h", r, v, exp_v[r]); end
    end
    checks++; if (mem_word(200) !== 32'h00000007) begin failures++; $display("FAIL sb mem[200]: got %h want 00000007", mem_word(200)); end
    checks++; if (mem_word(204) !== 32'h0000FFF8) begin failures++; $display("FAIL sh mem[204]: got %h want 0000fff8", mem_word(204)); end
    checks++; if (retired !== 32'd8 || pc !== 32'd32) begin
      failures++; $display("FAIL alu retired/pc: got %0d/%h want 8/20", retired, pc); end
  endtask

  task automatic test_halt();
    reset_on(); clear_mem();
    put_word(0, enc_i(1, 0, 0, 1, 7'h13));
    put_word(4, enc_i(2, 0, 0, 2, 7'h13));
    reset_off();
    step(5);
    checks++; if (halted !== 1'b0 || pc !== 32'd8) begin
      failures++; $display("FAIL halt pre: halted=%b pc=%h want 0/8", halted, pc); end
    step(1);
    checks++; if (halted !== 1'b1 || pc !== 32'd8 || mem_req !== 1'b0 || retired !== 32'd2) begin
      failures++; $display("FAIL halt: halted=%b pc=%h req=%b retired=%0d want 1/8/0/2", halted, pc, mem_req, retired); end
    step(3);
    checks++; if (halted !== 1'b1 || pc !== 32'd8 || mem_req !== 1'b0) begin
      failures++; $display("FAIL halt sticky: halted=%b pc=%h req=%b want 1/8/0", halted, pc, mem_req); end
    reset_on();
    #1;
    checks++; if (pc !== 32'h0 || halted !== 1'b0 || retired !== 32'h0) begin
      failures++; $display("FAIL halt recover: pc=%h halted=%b retired=%0d want 0/0/0", pc, halted, retired); end
  endtask

  task automatic test_rv32e();
    reset_on();
    reset_off();
    checks++; if (halted_e !== 1'b0 || mem_req_e !== 1'b1 || mem_addr_e !== 32'h100) begin
      failures++; $display("FAIL rv32e start: halted=%b req=%b addr=%h want 0/1/100", halted_e, mem_req_e, mem_addr_e); end
    step(3);
    checks++; if (halted_e !== 1'b1 || pc_e !== 32'h100 || mem_req_e !== 1'b0 || retired_e !== 32'h0) begin
      failures++; $display("FAIL rv32e halt: halted=%b pc=%h req=%b retired=%0d want 1/100/0/0", halted_e, pc_e, mem_req_e, retired_e); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] v;
    int sc0;
    reset_on(); clear_mem();
    put_word(100, 32'h12345678);
    put_word(0, enc_i(32'h55, 0, 0, 1, 7'h13));
    put_word(4, enc_s(100, 1, 0, 2));
    wait_cfg = 3;
    sc0 = store_count;
    reset_off();
    step(11);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd100) begin
      failures++; $display("FAIL midreset pre: req=%b we=%b addr=%h want 1/1/64", mem_req, mem_we, mem_addr); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midreset req drop: got %b want 0", mem_req); end
    step(2);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midreset pc: got %h want 0", pc); end
    checks++; if (mem_word(100) !== 32'h12345678 || store_count !== sc0) begin
      failures++; $display("FAIL midreset store: mem=%h stores=%0d want 12345678/%0d", mem_word(100), store_count, sc0); end
    read_reg(1, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midreset x1: got %h want 0", v); end
    wait_cfg = 0;
  endtask

  initial begin
    reset    = 1'b1;
    dbg_rsel = 5'd0;
    test_reset();
    test_addi_seq();
    test_store_load();
    test_wait_states();
    test_loads();
    test_alu();
    test_halt();
    test_rv32e();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
